// File: rtl/param_fifo_pkg.sv
// Shared defaults and sizing helpers for the parameterised FIFO.
package param_fifo_pkg;

    localparam int PARAM_FIFO_DEF_WIDTH = 8;
    localparam int PARAM_FIFO_DEF_DEPTH = 4;

    // Ceiling log2 that never returns less than one bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module param_fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int WIDTH  = PARAM_FIFO_DEF_WIDTH,
    parameter int DEPTH  = PARAM_FIFO_DEF_DEPTH,
    parameter int ADDR_W = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_fifo.sv
// Synchronous valid/ready FIFO with optional fall-through and a level high-water mark.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH        = PARAM_FIFO_DEF_WIDTH,
    parameter int DEPTH        = PARAM_FIFO_DEF_DEPTH,
    parameter bit FALL_THROUGH = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [clog2_min1(DEPTH+1)-1:0]     count,
    output logic [clog2_min1(DEPTH+1)-1:0]     max_count
);

    localparam int ADDR_W = clog2_min1(DEPTH);
    localparam int CNT_W  = clog2_min1(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "param_fifo: WIDTH must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "param_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [WIDTH-1:0]  mem_rdata_s;
    logic              empty_s;
    logic              full_s;
    logic              bypass_mode_s;
    logic              bypass_s;
    logic              wr_en_s;
    logic              rd_en_s;

    param_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rdata_s)
    );

    // Handshake outputs, bypass detection and next-state for pointers and counters.
    always_comb begin
        empty_s       = (count_q == {CNT_W{1'b0}});
        full_s        = (count_q == FULL_CNT);
        in_ready      = ~full_s;
        bypass_mode_s = FALL_THROUGH && empty_s;

        // An empty fall-through FIFO presents the producer's word directly.
        if (bypass_mode_s) begin
            out_valid = in_valid;
            out_data  = in_data;
        end else begin
            out_valid = ~empty_s;
            out_data  = mem_rdata_s;
        end

        bypass_s = bypass_mode_s && in_valid && out_ready;
        wr_en_s  = in_valid && in_ready && !bypass_s;
        rd_en_s  = out_valid && out_ready && !bypass_s;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (count_d > max_q) begin
            max_d = count_d;
        end else begin
            max_d = max_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            max_q    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    assign count     = count_q;
    assign max_count = max_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a plain and a fall-through instance share stimulus, each checked against a queue model.
module tb_param_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;

    logic       ir  [2];
    logic       ov  [2];
    logic [7:0] od  [2];
    logic [2:0] cnt [2];
    logic [2:0] mxc [2];

    int vectors;
    int miscompares;
    int cyc;

    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    int         mx0;
    int         mx1;

    param_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FALL_THROUGH(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir[0]), .in_data(id),
        .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]),
        .count(cnt[0]), .max_count(mxc[0])
    );

    param_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FALL_THROUGH(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir[1]), .in_data(id),
        .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]),
        .count(cnt[1]), .max_count(mxc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one instance against the queue model and report what transfers the model expects.
    task automatic chk(input int k, input int sz, input logic [7:0] head, input int mx,
                       output bit wr, output bit rd);
        bit         ft_mode;
        bit         e_ir;
        bit         e_ov;
        logic [7:0] e_od;
        ft_mode = (k == 1) && (sz == 0);
        e_ir    = (sz != DEPTH);
        e_ov    = ft_mode ? iv : (sz != 0);
        e_od    = ft_mode ? id : head;
        vectors++;
        if (ir[k] !== e_ir) begin
            miscompares++;
            $display("FAIL in_ready dut%0d cyc %0d: got %b exp %b", k, cyc, ir[k], e_ir);
        end
        vectors++;
        if (ov[k] !== e_ov) begin
            miscompares++;
            $display("FAIL out_valid dut%0d cyc %0d: got %b exp %b", k, cyc, ov[k], e_ov);
        end
        if (e_ov) begin
            vectors++;
            if (od[k] !== e_od) begin
                miscompares++;
                $display("FAIL out_data dut%0d cyc %0d: got %h exp %h", k, cyc, od[k], e_od);
            end
        end
        vectors++;
        if (cnt[k] !== 3'(sz)) begin
            miscompares++;
            $display("FAIL count dut%0d cyc %0d: got %0d exp %0d", k, cyc, cnt[k], sz);
        end
        vectors++;
        if (mxc[k] !== 3'(mx)) begin
            miscompares++;
            $display("FAIL max_count dut%0d cyc %0d: got %0d exp %0d", k, cyc, mxc[k], mx);
        end
        wr = iv && e_ir && !(ft_mode && ordy);
        rd = !ft_mode && e_ov && ordy;
    endtask

    // One clock: check before the edge, advance the models at the edge.
    task automatic step();
        bit wr0, rd0, wr1, rd1;
        @(negedge clk);
        chk(0, mq0.size(), (mq0.size() > 0) ? mq0[0] : 8'h00, mx0, wr0, rd0);
        chk(1, mq1.size(), (mq1.size() > 0) ? mq1[0] : 8'h00, mx1, wr1, rd1);
        @(posedge clk);
        if (rst) begin
            mq0.delete();
            mq1.delete();
            mx0 = 0;
            mx1 = 0;
        end else begin
            if (rd0) void'(mq0.pop_front());
            if (wr0) mq0.push_back(id);
            if (rd1) void'(mq1.pop_front());
            if (wr1) mq1.push_back(id);
            if (mq0.size() > mx0) mx0 = mq0.size();
            if (mq1.size() > mx1) mx1 = mq1.size();
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        iv   = v;
        id   = d;
        ordy = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (cnt[0] !== 3'd0 || mxc[0] !== 3'd0 || ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got cnt %0d max %0d ir %b ov %b exp 0 0 1 0",
                     cnt[0], mxc[0], ir[0], ov[0]);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 1'b0);
            step();
        end
        vectors++;
        if (cnt[0] !== 3'd4 || ir[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL fill: got cnt %0d ir %b exp 4 0", cnt[0], ir[0]);
        end
        drive(1'b1, 8'h55, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            vectors++;
            if (od[0] !== words[i] || ov[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_order %0d: got %h exp %h", i, od[0], words[i]);
            end
            step();
        end
        vectors++;
        if (cnt[0] !== 3'd0 || mxc[0] !== 3'd4) begin
            miscompares++;
            $display("FAIL drain_end: got cnt %0d max %0d exp 0 4", cnt[0], mxc[0]);
        end
    endtask

    task automatic test_full_read();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b0);
            step();
        end
        drive(1'b1, 8'hEE, 1'b1);
        step();
        vectors++;
        if (cnt[0] !== 3'd3 || ir[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL full_read: got cnt %0d ir %b exp 3 1", cnt[0], ir[0]);
        end
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_stream();
        drive(1'b1, 8'h60, 1'b0);
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1);
            step();
            vectors++;
            if (cnt[0] !== 3'd1) begin
                miscompares++;
                $display("FAIL stream_count %0d: got %0d exp 1", i, cnt[0]);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        step();
    endtask

    task automatic test_fall_through();
        drive(1'b1, 8'hA5, 1'b1);
        #1;
        vectors++;
        if (od[1] !== 8'hA5 || ov[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL ft_bypass: got ov %b data %h exp 1 a5", ov[1], od[1]);
        end
        step();
        vectors++;
        if (cnt[1] !== 3'd0) begin
            miscompares++;
            $display("FAIL ft_bypass_count: got %0d exp 0", cnt[1]);
        end
        drive(1'b1, 8'hA5, 1'b0);
        step();
        vectors++;
        if (cnt[1] !== 3'd1 || od[1] !== 8'hA5) begin
            miscompares++;
            $display("FAIL ft_store: got cnt %0d data %h exp 1 a5", cnt[1], od[1]);
        end
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (cnt[0] !== 3'd0 || mxc[0] !== 3'd0 || ov[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got cnt %0d max %0d ov %b exp 0 0 0", cnt[0], mxc[0], ov[0]);
        end
        drive(1'b1, 8'h7E, 1'b0);
        step();
        vectors++;
        if (od[0] !== 8'h7E || cnt[0] !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_new_data: got %h cnt %0d exp 7e 1", od[0], cnt[0]);
        end
        drive(1'b0, 8'h00, 1'b1);
        step();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
            rst = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        mx0         = 0;
        mx1         = 0;
        rst         = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_full_read();
        test_stream();
        test_fall_through();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
